// File: rtl/snn_weight_arbiter.sv
`timescale 1ns/1ps
// snn_weight_arbiter
// Shares one single-port weight BRAM between NUM_REQ layer engines (reads)
// and the host weight loader (writes). Host writes win outright. Reads are
// granted to the current burst owner until it stops requesting or hits
// MAX_BURST. After that, grants rotate round-robin. Granted reads are tagged
// with a one-hot requester id that travels beside the BRAM latency, so data
// comes back to the right engine a fixed 2+MEM_LATENCY cycles after accept.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_read_en       per-requester level read request
//   req_addr          packed read addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready         one-hot combinational grant (accept = en && ready)
//   rsp_valid         one-hot single-cycle read-data valid
//   rsp_data          registered BRAM read data, broadcast
//   host_wr_en/addr/data, host_wr_ready   host write request and accept
//   mem_en/we/addr/wdata, mem_rdata       registered BRAM interface
//   busy              request pending or read in flight
//
// Optional build macro SNN_WEIGHT_ARB_STATS_EN adds the grant_count,
// stall_cycles and host_wr_count statistics outputs.
module snn_weight_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_read_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WEIGHT_WIDTH-1:0]       rsp_data,
  input  logic                          host_wr_en,
  input  logic [ADDR_WIDTH-1:0]         host_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]       host_wr_data,
  output logic                          host_wr_ready,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WEIGHT_WIDTH-1:0]       mem_wdata,
  input  logic [WEIGHT_WIDTH-1:0]       mem_rdata,
  output logic                          busy
`ifdef SNN_WEIGHT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_count,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   host_wr_count
`endif
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  // Arbitration state
  logic               owner_vld_q, owner_vld_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  // Combinational grant
  logic               host_acc;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant_oh;

  // Memory drive registers
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WEIGHT_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Tag pipeline (stage 0 = mem drive cycle) and response registers
  logic [MEM_LATENCY:0][NUM_REQ-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0]                rsp_valid_q, rsp_valid_d;
  logic [WEIGHT_WIDTH-1:0]           rsp_data_q, rsp_data_d;

  // Grant selection. Combinational outputs are forced low while in reset.
  always_comb begin
    host_acc  = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rst_n) begin
      if (host_wr_en) begin
        host_acc = 1'b1;
      end else if (owner_vld_q && req_read_en[owner_q] && (burst_cnt_q < BURST_MAX)) begin
        grant_vld = 1'b1;
        grant_idx = owner_q;
      end else begin
        // Scan ends at rr_ptr itself, so a lone requester is always re-granted.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
          if (!grant_vld && req_read_en[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // Owner / burst bookkeeping. A host cycle leaves the burst untouched
  // unless the owner has dropped its request.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (grant_vld) begin
      if (owner_vld_q && (grant_idx == owner_q)) begin
        if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end else begin
        owner_vld_d = 1'b1;
        owner_d     = grant_idx;
        rr_ptr_d    = grant_idx;
        burst_cnt_d = BURST_W'(1);
      end
    end else if (owner_vld_q && !req_read_en[owner_q]) begin
      owner_vld_d = 1'b0;
      burst_cnt_d = '0;
    end
  end

  // Memory drive and read return
  always_comb begin
    mem_en_d    = host_acc | grant_vld;
    mem_we_d    = host_acc;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (host_acc) begin
      mem_addr_d  = host_wr_addr;
      mem_wdata_d = host_wr_data;
    end else if (grant_vld) begin
      mem_addr_d  = req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
    tag_d       = {tag_q[MEM_LATENCY-1:0], grant_oh};
    rsp_valid_d = tag_q[MEM_LATENCY];
    rsp_data_d  = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready     = grant_oh;
  assign host_wr_ready = host_acc;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = rst_n & ((|req_read_en) | host_wr_en | (|tag_q));

`ifdef SNN_WEIGHT_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              stall_cnt_q, stall_cnt_d;
  logic [31:0]              host_cnt_q, host_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    end
    stall_cnt_d = stall_cnt_q + {31'd0, |(req_read_en & ~grant_oh)};
    host_cnt_d  = host_cnt_q + {31'd0, host_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
      host_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      host_cnt_q  <= host_cnt_d;
    end
  end

  assign grant_count   = grant_cnt_q;
  assign stall_cycles  = stall_cnt_q;
  assign host_wr_count = host_cnt_q;
`endif

endmodule
